// File: rtl/csc_pkg.sv
// Shared definitions for the colour-space converter: mode encodings, the fixed-point
// coefficient set (FRAC=10) and the output clamp helper.
package csc_pkg;

    typedef enum logic {
        CSC_YCC2RGB = 1'b0,
        CSC_RGB2YCC = 1'b1
    } csc_mode_e;

    // YCrCb -> RGB, BT.601 full range; the Y weight is 1.0 in Q10
    localparam int K_R_Y  = 1024;
    localparam int K_R_CB = 0;
    localparam int K_R_CR = 1436;
    localparam int K_G_Y  = 1024;
    localparam int K_G_CB = -352;
    localparam int K_G_CR = -731;
    localparam int K_B_Y  = 1024;
    localparam int K_B_CB = 1815;
    localparam int K_B_CR = 0;

    // RGB -> YCrCb
    localparam int K_Y_R  = 306;
    localparam int K_Y_G  = 601;
    localparam int K_Y_B  = 117;
    localparam int K_CB_R = -173;
    localparam int K_CB_G = -339;
    localparam int K_CB_B = 512;
    localparam int K_CR_R = 512;
    localparam int K_CR_G = -429;
    localparam int K_CR_B = -83;

    function automatic int coef(input csc_mode_e mode, input int unsigned comp,
                                input int unsigned term);
        int row [3];
        if (mode == CSC_YCC2RGB) begin
            case (comp)
                0:       row = '{K_R_Y, K_R_CB, K_R_CR};
                1:       row = '{K_G_Y, K_G_CB, K_G_CR};
                default: row = '{K_B_Y, K_B_CB, K_B_CR};
            endcase
        end else begin
            case (comp)
                0:       row = '{K_Y_R, K_Y_G, K_Y_B};
                1:       row = '{K_CB_R, K_CB_G, K_CB_B};
                default: row = '{K_CR_R, K_CR_G, K_CR_B};
            endcase
        end
        case (term)
            0:       return row[0];
            1:       return row[1];
            default: return row[2];
        endcase
    endfunction

    function automatic longint clamp(input longint v, input int unsigned w);
        longint hi;
        hi = (longint'(1) << w) - 1;
        if (v < 0)
            return 0;
        if (v > hi)
            return hi;
        return v;
    endfunction

endpackage

// File: rtl/csc_mac3.sv
// One output component: registered three-term signed products (stage 2), then
// sum, round, arithmetic shift and clamp (stage 3). Sat flag only with CSC_SAT_CNT_EN.
module csc_mac3
    import csc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH:0]   a0,
    input  logic signed [WIDTH:0]   a1,
    input  logic signed [WIDTH:0]   a2,
    input  logic signed [12:0]      k0,
    input  logic signed [12:0]      k1,
    input  logic signed [12:0]      k2,
    input  logic signed [WIDTH:0]   bias,
    output logic [WIDTH-1:0]        res
`ifdef CSC_SAT_CNT_EN
   ,output logic                    sat
`endif
);

    localparam int IW = WIDTH + FRAC + 4;
    localparam logic signed [IW-1:0] RND = IW'(1) <<< (FRAC - 1);
    localparam longint HI = (longint'(1) << WIDTH) - 1;

    logic signed [IW-1:0] p0, p1, p2, pb;
    logic signed [IW-1:0] sum, scaled;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
            pb <= '0;
        end else if (en) begin
            p0 <= IW'(a0) * IW'(k0);
            p1 <= IW'(a1) * IW'(k1);
            p2 <= IW'(a2) * IW'(k2);
            pb <= IW'(bias) <<< FRAC;
        end
    end

    always_comb begin
        sum    = p0 + p1 + p2 + pb + RND;
        scaled = sum >>> FRAC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res <= '0;
`ifdef CSC_SAT_CNT_EN
            sat <= 1'b0;
`endif
        end else if (en) begin
            res <= WIDTH'(clamp(longint'(scaled), WIDTH));
`ifdef CSC_SAT_CNT_EN
            sat <= (scaled < 0) || (longint'(scaled) > HI);
`endif
        end
    end

endmodule

// File: rtl/csc_pipe.sv
// 3-stage YCrCb<->RGB converter with per-pixel mode and a global stall enable.
// Optional CSC_SAT_CNT_EN adds a saturating count of clamped output pixels.
module csc_pipe
    import csc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_c0,
    input  logic [WIDTH-1:0] in_c1,
    input  logic [WIDTH-1:0] in_c2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c0,
    output logic [WIDTH-1:0] out_c1,
    output logic [WIDTH-1:0] out_c2,
    output logic             out_mode
`ifdef CSC_SAT_CNT_EN
   ,output logic [15:0]      sat_cnt
`endif
);

    localparam int OFS = 1 << (WIDTH - 1);

    logic                  en;
    logic                  s1_valid, s2_valid;
    csc_mode_e             s1_mode, s2_mode;
    logic signed [WIDTH:0] s1_a [3];
    logic signed [12:0]    k [3][3];
    logic signed [WIDTH:0] bias [3];
    logic [WIDTH-1:0]      res [3];

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= CSC_YCC2RGB;
            s1_a[0]  <= '0;
            s1_a[1]  <= '0;
            s1_a[2]  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_mode  <= csc_mode_e'(in_mode);
            s1_a[0]  <= $signed({1'b0, in_c0});
            if (csc_mode_e'(in_mode) == CSC_YCC2RGB) begin
                s1_a[1] <= $signed({1'b0, in_c1}) - (WIDTH+1)'(OFS);
                s1_a[2] <= $signed({1'b0, in_c2}) - (WIDTH+1)'(OFS);
            end else begin
                s1_a[1] <= $signed({1'b0, in_c1});
                s1_a[2] <= $signed({1'b0, in_c2});
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_mode   <= CSC_YCC2RGB;
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_mode   <= s1_mode;
            out_valid <= s2_valid;
            out_mode  <= s2_mode;
        end
    end

    // Coefficients and the chroma offset follow the mode of the pixel in stage 1,
    // so each pixel is multiplied with its own matrix.
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            for (int unsigned t = 0; t < 3; t++)
                k[c][t] = 13'(coef(s1_mode, c, t));
            bias[c] = (s1_mode == CSC_RGB2YCC && c != 0) ? (WIDTH+1)'(OFS) : '0;
        end
    end

`ifdef CSC_SAT_CNT_EN
    logic [2:0] sat;
`endif

    for (genvar c = 0; c < 3; c++) begin : g_mac
        csc_mac3 #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_mac (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .a0   (s1_a[0]),
            .a1   (s1_a[1]),
            .a2   (s1_a[2]),
            .k0   (k[c][0]),
            .k1   (k[c][1]),
            .k2   (k[c][2]),
            .bias (bias[c]),
            .res  (res[c])
`ifdef CSC_SAT_CNT_EN
           ,.sat  (sat[c])
`endif
        );
    end

    assign out_c0 = res[0];
    assign out_c1 = res[1];
    assign out_c2 = res[2];

`ifdef CSC_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_cnt <= '0;
        else if (out_valid && out_ready && (|sat) && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/csc_pipe.md
CSC_PIPE -- requirements
Module: csc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per colour component (legal range 6..12).
REQ-002 SHALL have parameter FRAC, default 10, meaning fractional bits of the fixed-point coefficients.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input pixel present.
REQ-006 SHALL have port in_ready, output, 1, block accepts the input pixel this cycle.
REQ-007 SHALL have port in_mode, input, 1; 0 selects YCrCb->RGB and 1 selects RGB->YCrCb, per pixel.
REQ-008 SHALL have ports in_c0, in_c1, in_c2, input, WIDTH each: Y/Cb/Cr when mode 0, and R/G/B when mode 1.
REQ-009 SHALL have port out_valid, output, 1, output pixel present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the output pixel.
REQ-011 SHALL have ports out_c0, out_c1, out_c2, output, WIDTH each: R/G/B when mode 0, and Y/Cb/Cr when mode 1.
REQ-012 SHALL have port out_mode, output, 1, the mode that travelled with the output pixel.

Function
REQ-013 The datapath SHALL be a 3-stage pipeline:
- Stage 1: register the inputs and subtract OFS = 2^(WIDTH-1) from the chroma inputs (mode 0 only).
- Stage 2: form the signed products.
- Stage 3: sum, round, shift and clamp.
REQ-014 Latency SHALL be exactly 3 clk cycles from an accepted input to out_valid when the pipeline is not stalled.
REQ-015 The pipeline SHALL use a global enable en = out_ready OR NOT out_valid.
- in_ready SHALL equal en.
- When en is 0, all stages SHALL hold their state.
- Bubbles SHALL NOT collapse.
REQ-016 A pixel SHALL be accepted only when in_valid and in_ready are both 1.
REQ-017 Each stage SHALL carry its own valid bit and its mode bit alongside its data.
REQ-018 The output data SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-019 Mode 0 coefficients SHALL be the BT.601 full-range set, scaled by 2^FRAC (1024 at FRAC=10):
- R = Y + 1436*Cr'
- G = Y - 352*Cb' - 731*Cr'
- B = Y + 1815*Cb'
- Here Cb' = Cb - OFS and Cr' = Cr - OFS.
REQ-020 Mode 1 coefficients SHALL be as follows:
- Y = 306R + 601G + 117B
- Cb = -173R - 339G + 512B, plus OFS
- Cr = 512R - 429G - 83B, plus OFS
REQ-021 Each output SHALL be computed as (Yterm*2^FRAC + sum of products + 2^(FRAC-1)) arithmetically shifted right by FRAC.
- The internal width SHALL be WIDTH+FRAC+4 signed bits, so no intermediate overflow can occur.
REQ-022 Each result SHALL be clamped to the range 0..2^WIDTH-1.
REQ-023 A pixel's mode SHALL never affect any other pixel; mixed-mode streams SHALL be converted pixel-exact.

Reset
REQ-024 When rst is 0, all valid bits SHALL clear immediately (asynchronously).
- out_valid SHALL be 0.
- out_c0..2 and out_mode SHALL be 0.
- in_ready SHALL then be 1, since out_valid is 0.
REQ-025 A reset asserted mid-stream SHALL discard all in-flight pixels, and no partial pixel SHALL be emitted after release.
REQ-026 The first input SHALL be accepted on the first clk edge after rst rises.

Configuration
REQ-027 When macro CSC_SAT_CNT_EN is defined, the block SHALL add output port sat_cnt, 16 bits.
- sat_cnt SHALL count output pixels in which at least one component was clamped.
- It SHALL increment on an out_valid AND out_ready handshake.
- It SHALL saturate at 0xFFFF.
- It SHALL be cleared by reset.
REQ-028 When CSC_SAT_CNT_EN is not defined, the port and the counter logic SHALL be absent, and the datapath SHALL be unchanged.

Structure
REQ-029 A shared package csc_pkg SHALL hold:
- the mode encodings CSC_YCC2RGB=0 and CSC_RGB2YCC=1;
- the 18 coefficient constants, for FRAC=10;
- a clamp function.
REQ-030 One sub-module, csc_mac3, SHALL be instantiated three times (once per output component). It SHALL implement the three-term signed multiply-accumulate, round and clamp for one component.

Verification
REQ-031 Mode 0 with Y=72, Cb=130, Cr=173 -> R=135, G=39, B=76, with out_valid exactly 3 cycles after acceptance.
REQ-032 Mode 0 with Y=255, Cb=128, Cr=255 -> R=255 (clamped) and B=255. Then Y=0, Cb=128, Cr=0 -> R=0 (clamped). With CSC_SAT_CNT_EN defined, sat_cnt=2.
REQ-033 Mode 1 with R=G=B=200 -> Y=200, Cb=128, Cr=128.
REQ-034 A back-to-back mixed-mode stream with out_ready held at 0 for 5 cycles after the 2nd output:
- the outputs SHALL stay stable and in_ready SHALL be 0;
- no pixel SHALL be lost or duplicated;
- every out_mode SHALL match its input.
REQ-035 rst pulsed low while 3 pixels are in flight -> out_valid=0 and outputs=0 immediately, and no stale pixel SHALL appear after release.
REQ-036 WIDTH=10 with mode 0, Y=512, Cb=512, Cr=512 -> R=G=B=512.
